// File: rtl/rv32i_pkg.sv
// RV32I encodings shared by the decode/execute blocks: ALU ops, branch conditions,
// forwarding selects and base opcodes.
package rv32i_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_PASSB = 4'b1001,
        ALU_JALR = 4'b1010,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ    = 3'b000,
        BR_NE    = 3'b001,
        BR_JUMP  = 3'b010,
        BR_NEVER = 3'b011,
        BR_LT    = 3'b100,
        BR_GE    = 3'b101,
        BR_LTU   = 3'b110,
        BR_GEU   = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU; unknown op codes yield zero.
import rv32i_pkg::*;

module alu #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [3:0]      i_alu_op,
    output logic [XLEN-1:0] o_result
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_sum;

    assign w_shamt = i_b[SHW-1:0];
    assign w_sum   = i_a + i_b;

    always_comb begin
        o_result = '0;
        case (i_alu_op)
            ALU_ADD:   o_result = w_sum;
            ALU_SUB:   o_result = i_a - i_b;
            ALU_SLL:   o_result = i_a << w_shamt;
            ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, i_a < i_b};
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_SRL:   o_result = i_a >> w_shamt;
            ALU_SRA:   o_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_OR:    o_result = i_a | i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_PASSB: o_result = i_b;
            ALU_JALR:  o_result = w_sum & ~{{(XLEN-1){1'b0}}, 1'b1};
            default:   o_result = '0;
        endcase
    end
endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution with a one-shot
// fetch redirect, and the EX/MEM pipeline register.
import rv32i_pkg::*;

module ex_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rd,
    input  logic            id_reg_we,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic [2:0]      id_funct3,
    input  logic            a_sel,
    input  logic            b_sel,
    input  logic [3:0]      alu_op,
    input  logic [2:0]      branch_alu_op,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic            stall,
    input  logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_result,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_we,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [2:0]      ex_funct3,
    output logic [XLEN-1:0] ex_pc,
    output logic            ex_misaligned
);
    logic [XLEN-1:0] w_rs1, w_rs2, w_op_a, w_op_b, w_alu, w_target, w_link;
    logic            w_cond, w_is_jump, w_taken, w_misaligned;

    logic            r_fired;
    logic            r_valid, r_reg_we, r_mem_read, r_mem_write, r_misaligned;
    logic [XLEN-1:0] r_result, r_store_data, r_pc;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;

    // Code 11 is unused and falls back to the register-file value.
    always_comb begin
        case (fwd_a)
            FWD_MEM: w_rs1 = mem_fwd_data;
            FWD_WB:  w_rs1 = wb_fwd_data;
            default: w_rs1 = id_rs1_data;
        endcase
        case (fwd_b)
            FWD_MEM: w_rs2 = mem_fwd_data;
            FWD_WB:  w_rs2 = wb_fwd_data;
            default: w_rs2 = id_rs2_data;
        endcase
    end

    assign w_op_a = a_sel ? id_pc  : w_rs1;
    assign w_op_b = b_sel ? id_imm : w_rs2;

    alu #(.XLEN(XLEN)) u_alu (
        .i_a      (w_op_a),
        .i_b      (w_op_b),
        .i_alu_op (alu_op),
        .o_result (w_alu)
    );

    always_comb begin
        w_cond = 1'b0;
        case (branch_alu_op)
            BR_EQ:    w_cond = (w_rs1 == w_rs2);
            BR_NE:    w_cond = (w_rs1 != w_rs2);
            BR_LT:    w_cond = ($signed(w_rs1) <  $signed(w_rs2));
            BR_GE:    w_cond = ($signed(w_rs1) >= $signed(w_rs2));
            BR_LTU:   w_cond = (w_rs1 <  w_rs2);
            BR_GEU:   w_cond = (w_rs1 >= w_rs2);
            BR_JUMP:  w_cond = 1'b1;
            default:  w_cond = 1'b0;
        endcase
    end

    assign w_is_jump = (branch_alu_op == BR_JUMP);
    assign w_target  = w_is_jump ? w_alu : (id_pc + id_imm);
    assign w_link    = id_pc + XLEN'(4);

    // Bit 0 of every target is already clear, so bit 1 alone flags misalignment.
    assign w_taken      = id_valid & w_cond & ~flush & ~r_fired & ~w_target[1];
    assign w_misaligned = id_valid & w_cond & w_target[1];

    assign redirect_valid = w_taken;
    assign redirect_pc    = w_target;

    // Remembers that a stalled instruction already redirected fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_fired <= 1'b0;
        else if (flush)           r_fired <= 1'b0;
        else if (w_taken & stall) r_fired <= 1'b1;
        else if (!stall)          r_fired <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_reg_we     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_funct3     <= '0;
            r_pc         <= RESET_PC;
            r_misaligned <= 1'b0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_reg_we     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (!stall) begin
            r_valid      <= id_valid;
            r_result     <= w_is_jump ? w_link : w_alu;
            r_store_data <= w_rs2;
            r_rd         <= id_rd;
            r_reg_we     <= id_valid & id_reg_we & (id_rd != 5'd0);
            r_mem_read   <= id_valid & id_mem_read;
            r_mem_write  <= id_valid & id_mem_write;
            r_funct3     <= id_funct3;
            r_pc         <= id_pc;
            r_misaligned <= w_misaligned;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_result     = r_result;
    assign ex_store_data = r_store_data;
    assign ex_rd         = r_rd;
    assign ex_reg_we     = r_reg_we;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_funct3     = r_funct3;
    assign ex_pc         = r_pc;
    assign ex_misaligned = r_misaligned;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios followed by random traffic, all checked
// against an arithmetic reference model of the execute stage.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_reg_we, id_mem_read, id_mem_write, a_sel, b_sel, stall, flush;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, mem_fwd_data, wb_fwd_data;
    logic [4:0]  id_rd;
    logic [2:0]  id_funct3, branch_alu_op;
    logic [3:0]  alu_op;
    logic [1:0]  fwd_a, fwd_b;
    logic        redirect_valid, ex_valid, ex_reg_we, ex_mem_read, ex_mem_write, ex_misaligned;
    logic [31:0] redirect_pc, ex_result, ex_store_data, ex_pc;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;

    ex_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rd(id_rd), .id_reg_we(id_reg_we), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_funct3(id_funct3), .a_sel(a_sel), .b_sel(b_sel),
        .alu_op(alu_op), .branch_alu_op(branch_alu_op), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ex_valid(ex_valid),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_misaligned(ex_misaligned)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected EX/MEM contents and one-shot state.
    typedef struct {
        logic        valid, we, mr, mw, mis, fired;
        logic [31:0] result, store, pc;
        logic [4:0]  rd;
        logic [2:0]  f3;
    } exm_t;
    exm_t m, m_nx;

    function automatic logic [31:0] fwd_m(input logic [1:0] s, input logic [31:0] r);
        if (s == 2'd1) return mem_fwd_data;
        if (s == 2'd2) return wb_fwd_data;
        return r;
    endfunction

    function automatic logic [31:0] alu_m(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh = int'(b % 32);
        longint sa = a[31] ? longint'(a) - 64'sd4294967296 : longint'(a);
        longint sb = b[31] ? longint'(b) - 64'sd4294967296 : longint'(b);
        logic [31:0] r;
        case (op)
            4'd0:  return a + b;
            4'd8:  return a - b;
            4'd1:  return a << sh;
            4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd3:  return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            4'd4:  return a ^ b;
            4'd5:  return a >> sh;
            4'd13: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
                return r;
            end
            4'd6:  return a | b;
            4'd7:  return a & b;
            4'd9:  return b;
            4'd10: return (a + b) & 32'hFFFF_FFFE;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic cond_m(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx = x[31] ? longint'(x) - 64'sd4294967296 : longint'(x);
        longint sy = y[31] ? longint'(y) - 64'sd4294967296 : longint'(y);
        case (op)
            3'd0: return x == y;
            3'd1: return x != y;
            3'd4: return sx < sy;
            3'd5: return sx >= sy;
            3'd6: return {32'd0, x} < {32'd0, y};
            3'd7: return {32'd0, x} >= {32'd0, y};
            3'd2: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Check combinational outputs for the current inputs and compute the next model state.
    task automatic comb_phase();
        logic [31:0] r1, r2, alu_r, tgt;
        logic cnd, tk;
        #1;
        r1    = fwd_m(fwd_a, id_rs1_data);
        r2    = fwd_m(fwd_b, id_rs2_data);
        alu_r = alu_m(alu_op, a_sel ? id_pc : r1, b_sel ? id_imm : r2);
        cnd   = cond_m(branch_alu_op, r1, r2);
        tgt   = (branch_alu_op == 3'd2) ? alu_r : id_pc + id_imm;
        tk    = id_valid && cnd && !flush && !m.fired && !tgt[1];
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, tk});
        chk("redirect_pc", redirect_pc, tgt);
        m_nx = m;
        if (flush) begin
            {m_nx.valid, m_nx.we, m_nx.mr, m_nx.mw, m_nx.mis} = '0;
            m_nx.fired = 1'b0;
        end else begin
            if (tk && stall) m_nx.fired = 1'b1;
            else if (!stall) m_nx.fired = 1'b0;
            if (!stall) begin
                m_nx.valid  = id_valid;
                m_nx.result = (branch_alu_op == 3'd2) ? id_pc + 32'd4 : alu_r;
                m_nx.store  = r2;
                m_nx.rd     = id_rd;
                m_nx.we     = id_valid && id_reg_we && id_rd != 0;
                m_nx.mr     = id_valid && id_mem_read;
                m_nx.mw     = id_valid && id_mem_write;
                m_nx.f3     = id_funct3;
                m_nx.pc     = id_pc;
                m_nx.mis    = id_valid && cnd && tgt[1];
            end
        end
    endtask

    task automatic check_regs();
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
        chk("ex_result", ex_result, m.result);
        chk("ex_store_data", ex_store_data, m.store);
        chk("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
        chk("ex_reg_we", {31'd0, ex_reg_we}, {31'd0, m.we});
        chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m.mr});
        chk("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, m.mw});
        chk("ex_funct3", {29'd0, ex_funct3}, {29'd0, m.f3});
        chk("ex_pc", ex_pc, m.pc);
        chk("ex_misaligned", {31'd0, ex_misaligned}, {31'd0, m.mis});
    endtask

    task automatic edge_phase();
        @(posedge clk);
        m = m_nx;
        #1;
        check_regs();
    endtask

    task automatic step();
        comb_phase();
        edge_phase();
    endtask

    task automatic model_reset();
        m = '{default: '0};
    endtask

    task automatic clr_inputs();
        {id_valid, id_reg_we, id_mem_read, id_mem_write, a_sel, b_sel, stall, flush} = '0;
        {id_pc, id_rs1_data, id_rs2_data, id_imm, mem_fwd_data, wb_fwd_data} = '0;
        id_rd = 0; id_funct3 = 0; alu_op = 0; fwd_a = 0; fwd_b = 0;
        branch_alu_op = 3'b011;
    endtask

    task automatic rand_inputs();
        id_valid      = ($urandom_range(0, 9) != 0);
        id_pc         = $urandom & 32'hFFFF_FFFC;
        id_rs1_data   = $urandom;
        id_rs2_data   = ($urandom_range(0, 3) == 0) ? id_rs1_data : $urandom;
        id_imm        = $urandom_range(0, 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
        id_rd         = 5'($urandom);
        id_reg_we     = 1'($urandom);
        id_mem_read   = 1'($urandom);
        id_mem_write  = 1'($urandom);
        id_funct3     = 3'($urandom);
        a_sel         = 1'($urandom);
        b_sel         = 1'($urandom);
        alu_op        = 4'($urandom);
        branch_alu_op = 3'($urandom);
        fwd_a         = 2'($urandom);
        fwd_b         = 2'($urandom);
        mem_fwd_data  = $urandom;
        wb_fwd_data   = $urandom;
        stall         = ($urandom_range(0, 3) == 0);
        flush         = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        clr_inputs();
        rst = 1'b1;
        model_reset();
        #12;
        check_regs();
        chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ADD with EX/MEM forwarding on rs2
        id_valid = 1; id_rs1_data = 5; mem_fwd_data = 7; fwd_b = 2'b01; id_rd = 3; id_reg_we = 1;
        step();
        chk("add_fwd", ex_result, 32'd12);
        chk("add_valid", {31'd0, ex_valid}, 32'd1);

        // Arithmetic vs logical right shift
        clr_inputs(); id_valid = 1; id_rs1_data = 32'h8000_0000; id_imm = 4; b_sel = 1; alu_op = 4'b1101;
        step();
        chk("sra", ex_result, 32'hF800_0000);
        alu_op = 4'b0101;
        step();
        chk("srl", ex_result, 32'h0800_0000);

        // BLT taken, BLTU not taken with same operands
        clr_inputs(); id_valid = 1; id_pc = 32'h100; id_imm = 32'h20; id_rs1_data = 32'hFFFF_FFFF;
        id_rs2_data = 1; a_sel = 1; b_sel = 1; branch_alu_op = 3'b100;
        comb_phase();
        chk("blt_rv", {31'd0, redirect_valid}, 32'd1);
        chk("blt_pc", redirect_pc, 32'h120);
        edge_phase();
        branch_alu_op = 3'b110;
        comb_phase();
        chk("bltu_rv", {31'd0, redirect_valid}, 32'd0);
        edge_phase();

        // JALR to a misaligned target, then to an aligned one
        clr_inputs(); id_valid = 1; id_pc = 32'h40; id_rs1_data = 32'h203; b_sel = 1;
        alu_op = 4'b1010; branch_alu_op = 3'b010; id_rd = 1; id_reg_we = 1;
        comb_phase();
        chk("jalr_mis_pc", redirect_pc, 32'h202);
        chk("jalr_mis_rv", {31'd0, redirect_valid}, 32'd0);
        edge_phase();
        chk("jalr_mis_flag", {31'd0, ex_misaligned}, 32'd1);
        id_rs1_data = 32'h201;
        comb_phase();
        chk("jalr_pc", redirect_pc, 32'h200);
        chk("jalr_rv", {31'd0, redirect_valid}, 32'd1);
        edge_phase();
        chk("jalr_link", ex_result, 32'h44);

        // JAL held by stall for three cycles: single redirect, register frozen
        clr_inputs(); id_valid = 1; id_pc = 32'h80; id_imm = 32'h10; a_sel = 1; b_sel = 1;
        branch_alu_op = 3'b010; stall = 1;
        for (int i = 0; i < 3; i++) begin
            comb_phase();
            chk("jal_stall_rv", {31'd0, redirect_valid}, (i == 0) ? 32'd1 : 32'd0);
            edge_phase();
            chk("jal_stall_hold", ex_result, 32'h44);
        end
        stall = 0;
        step();
        chk("jal_load", ex_result, 32'h84);

        // Load a valid store, then flush together with stall
        clr_inputs(); id_valid = 1; id_mem_write = 1; id_rs2_data = 32'hDEAD_BEEF;
        step();
        chk("store_mw", {31'd0, ex_mem_write}, 32'd1);
        flush = 1; stall = 1;
        step();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_mw", {31'd0, ex_mem_write}, 32'd0);
        chk("flush_data_hold", ex_store_data, 32'hDEAD_BEEF);

        // Async reset mid-cycle
        clr_inputs(); id_valid = 1; id_rs1_data = 9; id_rd = 2; id_reg_we = 1; id_pc = 32'h300;
        step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_regs();
        @(posedge clk); #1;
        rst = 1'b0;
        step();
        chk("post_rst_load", ex_pc, 32'h300);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                check_regs();
                @(posedge clk); #1;
                rst = 1'b0;
            end
            rand_inputs();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the RV32I 5-stage pipeline; sits directly downstream of ex_ctrl and the ID/EX register.
- Consumes ex_ctrl outputs (a_sel, b_sel, alu_op, branch_alu_op), operand data and forwarding selects.
- Computes the ALU result, resolves branches/jumps and issues a one-shot fetch redirect.
- Registers results into the EX/MEM pipeline register, with stall and flush.

Parameters:
XLEN, 32, datapath width
RESET_PC, 32'h0000_0000, reset value of registered pc fields

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID/EX holds a valid instruction
id_pc  in  XLEN  instruction pc
id_rs1_data  in  XLEN  register-file rs1
id_rs2_data  in  XLEN  register-file rs2
id_imm  in  XLEN  sign-extended immediate
id_rd  in  5  destination register
id_reg_we  in  1  writes rd
id_mem_read  in  1  load
id_mem_write  in  1  store
id_funct3  in  3  load/store size, passed through
a_sel  in  1  0=rs1, 1=pc
b_sel  in  1  0=rs2, 1=imm
alu_op  in  4  ALU operation
branch_alu_op  in  3  branch condition
fwd_a  in  2  00=reg, 01=EX/MEM result, 10=WB result
fwd_b  in  2  same encoding, applies to rs2
mem_fwd_data  in  XLEN  EX/MEM forward value
wb_fwd_data  in  XLEN  WB forward value
stall  in  1  hold EX/MEM, do not accept
flush  in  1  insert bubble into EX/MEM
redirect_valid  out  1  fetch must jump (combinational)
redirect_pc  out  XLEN  jump target (combinational)
ex_valid  out  1  EX/MEM valid
ex_result  out  XLEN  ALU result, or pc+4 for jumps
ex_store_data  out  XLEN  forwarded rs2
ex_rd  out  5
ex_reg_we  out  1
ex_mem_read  out  1
ex_mem_write  out  1
ex_funct3  out  3
ex_pc  out  XLEN
ex_misaligned  out  1  taken target not word-aligned

Behaviour:
Operand selection:
- Forwarding muxes first; fwd code 11 is treated as 00.
- Operand A = a_sel ? id_pc : fwd rs1.
- Operand B = b_sel ? id_imm : fwd rs2.

ALU (modulo 2^32, combinational):
- 0000 ADD; 1000 SUB; 0001 SLL; 0010 SLT (signed); 0011 SLTU; 0100 XOR; 0101 SRL; 1101 SRA; 0110 OR; 0111 AND.
- 1001 pass B (LUI); 1010 (A+B) & ~1 (JALR).
- Shift amount is B[4:0]. Any other code produces 0.

Branch compare on forwarded rs1/rs2:
- 000 eq; 001 ne; 100 lt signed; 101 ge signed; 110 ltu; 111 geu.
- 010 always taken; 011 never taken.

Branch target:
- Jumps (010): target = ALU result.
- Conditional branches: target = id_pc + id_imm.
- ALU result for branches is computed with a_sel=1/b_sel=1, so it equals the target.

Redirect (combinational, one-shot):
- taken = id_valid & condition & ~flush & ~fired & ~target[1]. Bit 1 only is checked, since bit 0 is cleared or 0 for all targets.
- redirect_valid = taken; redirect_pc = target.
- State bit fired: set when redirect_valid & stall; cleared when stall=0 or flush=1. A stalled instruction therefore redirects exactly once.

Misaligned target:
- When condition holds and target[1]=1: no redirect, and ex_misaligned=1 is latched with the instruction.

EX/MEM register:
- Priority: rst > flush > stall > load.
- rst (async): all outputs 0, ex_pc=RESET_PC, fired=0.
- flush: ex_valid=0, ex_reg_we=0, ex_mem_read=0, ex_mem_write=0, ex_misaligned=0; data fields unchanged.
- stall: all EX/MEM fields hold.
- load: fields take current values.
  - ex_valid = id_valid.
  - Control bits are ANDed with id_valid.
  - ex_result = pc+4 when branch_alu_op=010, else the ALU result.
  - ex_rd = 0 forces ex_reg_we = 0.
- Latency: 1 cycle from ID/EX inputs to ex_*; 0 cycles to redirect.
- Reset deasserted mid-operation: first edge after release loads normally.

Decomposition:
Shared package rv32i_pkg holds:
- alu_op codes (ALU_ADD..ALU_JALR)
- branch_alu_op codes (BR_EQ..BR_NEVER)
- fwd select codes
- opcode constants already used by ex_ctrl

One sub-module: alu (pure combinational, a, b, alu_op -> result). Branch compare and EX/MEM register stay in ex_stage.

Test Plan:
- ADD with forwarding: rs1=5, mem_fwd_data=7, fwd_b=01, b_sel=0, alu_op=0000 -> next edge ex_result=12, ex_valid=1.
- SRA: A=32'h8000_0000, imm=4, b_sel=1, alu_op=1101 -> ex_result=32'hF800_0000; SRL with the same operands -> 32'h0800_0000.
- BLT taken: pc=0x100, imm=0x20, rs1=-1, rs2=1, branch_alu_op=100 -> redirect_valid=1, redirect_pc=0x120 same cycle. BLTU with the same operands -> redirect_valid=0.
- JALR: rs1=0x203, imm=0, pc=0x40, alu_op=1010, branch_alu_op=010 -> redirect_pc=0x202. Target bit 1 is set, so no redirect and ex_misaligned=1. With rs1=0x201 -> redirect_pc=0x200 and ex_result=0x44.
- JAL held by stall for 3 cycles -> redirect_valid high only in the first cycle; EX/MEM unchanged throughout. When stall drops, the register loads.
- flush and stall asserted together with a valid store -> ex_valid=0, ex_mem_write=0. Async rst mid-cycle -> all outputs 0 immediately, before the next edge.
